// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the WISC pipeline datapath and its hazard sequencer.
// The datapath side is master; the sequencer side is slave.
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [3:0]       id_rs1;
   logic [3:0]       id_rs2;
   logic             id_uses_rs1;
   logic             id_uses_rs2;
   logic             ex_valid;
   logic             ex_mem_to_reg;
   logic [3:0]       ex_reg_rd;
   logic             ex_redirect;
   logic             ex_ret;
   logic             sp_ready;
   logic             mem_stall;

   logic             pc_write;
   logic [1:0]       pc_src;
   logic             if_id_write;
   logic             if_id_flush;
   logic             id_ex_write;
   logic             id_ex_flush;
   logic             ex_mem_write;
   logic             ret_busy;
   logic             ret_error;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_mem_to_reg, ex_reg_rd, ex_redirect, ex_ret,
             sp_ready, mem_stall,
      input  pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, ret_busy, ret_error, stall_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
             ex_valid, ex_mem_to_reg, ex_reg_rd, ex_redirect, ex_ret,
             sp_ready, mem_stall,
      output pc_write, pc_src, if_id_write, if_id_flush, id_ex_write,
             id_ex_flush, ex_mem_write, ret_busy, ret_error, stall_count
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: per-cycle PC/stage-register strobes for load-use, redirect,
// multi-cycle return and memory-stall hazards, plus stall statistics.
module pipe_hazard_ctrl #(
   parameter int unsigned RET_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {RUN = 2'd0, RET_WAIT = 2'd1, HALT = 2'd2} state_e;
   typedef enum logic [1:0] {PC_SEQ = 2'b00, PC_EX = 2'b01, PC_RET = 2'b10} pc_src_e;

   localparam logic [7:0] RET_LAST = 8'(RET_TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [7:0]       ret_cnt_q, ret_cnt_d;
   logic             ret_error_q, ret_error_d;
   logic [CNT_W-1:0] stall_count_q, stall_count_d;

   logic    pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic    ex_mem_write, ret_busy;
   pc_src_e pc_src;
   logic    load_use;

   // r0 is hardwired zero, so a load targeting it never creates a dependency.
   assign load_use = bus.ex_valid && bus.ex_mem_to_reg && (bus.ex_reg_rd != 4'd0) &&
                     bus.id_valid &&
                     ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_reg_rd)) ||
                      (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_reg_rd)));

   always_comb begin
      // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latch).
      state_d      = state_q;
      ret_cnt_d    = ret_cnt_q;
      ret_error_d  = ret_error_q;
      pc_write     = 1'b1;
      pc_src       = PC_SEQ;
      if_id_write  = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_write  = 1'b1;
      id_ex_flush  = 1'b0;
      ex_mem_write = 1'b1;
      ret_busy     = 1'b0;

      unique case (state_q)
         RUN: begin
            if (bus.mem_stall) begin
               pc_write     = 1'b0;
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               ex_mem_write = 1'b0;
            end else if (bus.ex_valid && bus.ex_ret) begin
               pc_write    = 1'b0;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               state_d     = RET_WAIT;
               ret_cnt_d   = 8'd0;
            end else if (bus.ex_valid && bus.ex_redirect) begin
               pc_src      = PC_EX;
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
            end else if (load_use) begin
               pc_write    = 1'b0;
               if_id_write = 1'b0;
               id_ex_flush = 1'b1;
            end
         end
         RET_WAIT: begin
            ret_busy = 1'b1;
            pc_write = 1'b0;
            if (bus.mem_stall) begin
               if_id_write  = 1'b0;
               id_ex_write  = 1'b0;
               ex_mem_write = 1'b0;
            end else begin
               if_id_flush = 1'b1;
               id_ex_flush = 1'b1;
               if (bus.sp_ready) begin
                  pc_write = 1'b1;
                  pc_src   = PC_RET;
                  state_d  = RUN;
               end else if (ret_cnt_q == RET_LAST) begin
                  ret_error_d = 1'b1;
                  state_d     = HALT;
               end else begin
                  ret_cnt_d = ret_cnt_q + 8'd1;
               end
            end
         end
         HALT: begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
         end
         default: state_d = RUN;
      endcase

      // Reset overrides the decode so the pipeline fills with NOPs while held.
      if (!rst_n) begin
         pc_write     = 1'b0;
         pc_src       = PC_SEQ;
         if_id_write  = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_write  = 1'b0;
         id_ex_flush  = 1'b1;
         ex_mem_write = 1'b0;
         ret_busy     = 1'b0;
      end

      stall_count_d = stall_count_q;
      if (!pc_write && !(&stall_count_q))
         stall_count_d = stall_count_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
      if (!rst_n) begin
         state_q       <= RUN;
         ret_cnt_q     <= 8'd0;
         ret_error_q   <= 1'b0;
         stall_count_q <= '0;
      end else begin
         state_q       <= state_d;
         ret_cnt_q     <= ret_cnt_d;
         ret_error_q   <= ret_error_d;
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.pc_write     = pc_write;
   assign bus.pc_src       = pc_src;
   assign bus.if_id_write  = if_id_write;
   assign bus.if_id_flush  = if_id_flush;
   assign bus.id_ex_write  = id_ex_write;
   assign bus.id_ex_flush  = id_ex_flush;
   assign bus.ex_mem_write = ex_mem_write;
   assign bus.ret_busy     = ret_busy;
   assign bus.ret_error    = ret_error_q;
   assign bus.stall_count  = stall_count_q;
endmodule
